// File: rtl/demux16_dist_if.sv
// Bundles the handshake signals of demux16_dist.
//   upstream side : in_valid, in_ready, in_sel, in_data
//   downstream    : out_valid[15:0], out_ready[15:0], out_data
//   drop status   : drop_pulse, drop_cnt
//   debug         : state_dbg (0 = EMPTY, 1 = FULL)
// Modports:
//   slave  - the distributor itself
//   master - whatever drives the distributor and consumes its outputs
//
// Valid/ready rule for every channel on this interface: a transfer happens
// on the rising clock edge where valid and ready are both high; valid does
// not depend on ready, and a producer holding valid keeps its data stable
// until that transfer.
interface demux16_dist_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_sel;
  logic [DATA_W-1:0] in_data;
  logic [15:0]       out_valid;
  logic [15:0]       out_ready;
  logic [DATA_W-1:0] out_data;
  logic              drop_pulse;
  logic [CNT_W-1:0]  drop_cnt;
  logic              state_dbg;

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, drop_pulse, drop_cnt, state_dbg
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, drop_pulse, drop_cnt, state_dbg
  );
endinterface

// File: rtl/demux16_dist.sv
// Registered 1-to-16 distributor. One word plus a 4-bit destination select
// is accepted over a valid/ready handshake, held in an output register and
// presented to exactly one of 16 destination channels. Destination 15 is
// reserved: words sent there are consumed, dropped and counted.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - demux16_dist_if.slave: in_valid/in_ready/in_sel/in_data,
//            out_valid[15:0]/out_ready[15:0]/out_data, drop_pulse, drop_cnt,
//            state_dbg
module demux16_dist #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input logic           clk,
  input logic           rst_n,
  demux16_dist_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [3:0]       SEL_DROP = 4'd15;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        sel_q, sel_d;
  logic              drop_pulse_q, drop_pulse_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic in_ready;
  logic accept;
  logic complete;
  logic is_drop;

  // Only the ready bit of the held destination matters; while EMPTY the
  // stale sel_q is irrelevant because the EMPTY term already forces ready.
  assign in_ready = (state_q == EMPTY) || bus.out_ready[sel_q];
  assign accept   = bus.in_valid && in_ready;
  assign complete = (state_q == FULL) && bus.out_ready[sel_q];
  assign is_drop  = (bus.in_sel == SEL_DROP);

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sel_d        = sel_q;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;

    if (complete) begin
      state_d = EMPTY;
    end

    // Data/select are only sampled on accept, which requires in_valid, so
    // don't-care values on an idle bus never reach the held registers.
    if (accept) begin
      if (is_drop) begin
        // Accept from FULL implies the held word completes this cycle, so
        // a dropped word always leaves the block EMPTY.
        state_d      = EMPTY;
        drop_pulse_d = 1'b1;
        if (drop_cnt_q != CNT_MAX) begin
          drop_cnt_d = drop_cnt_q + 1'b1;
        end
      end else begin
        state_d = FULL;
        data_d  = bus.in_data;
        sel_d   = bus.in_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      sel_q        <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // sel_q never holds 15 while FULL, so bit 15 of out_valid stays low.
  assign bus.out_valid  = (state_q == FULL) ? (16'b1 << sel_q) : 16'b0;
  assign bus.out_data   = data_q;
  assign bus.in_ready   = in_ready;
  assign bus.drop_pulse = drop_pulse_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.state_dbg  = state_q;

endmodule
